axis_frame_len_limit: RTL and testbench
=======================================

// Module: axis_frame_len_limit
// PURPOSE
// - AXI4-Stream frame length checker/limiter; sits directly downstream of axis_fifo (FRAME_FIFO=0 or 1).
// - Counts bytes per frame, truncates frames exceeding length_max, and flags runts below length_min.
// - Drives the tuser bad-frame bit on the final output beat of each violating frame.
// - Reports per-frame length and violation status pulses.
// PARAMETERS
// - DATA_WIDTH            8               tdata width, multiple of 8
// - KEEP_ENABLE           (DATA_WIDTH>8)  tkeep used for byte count; else every beat = KEEP_WIDTH bytes
// - KEEP_WIDTH            (DATA_WIDTH/8)  tkeep width
// - USER_WIDTH            1               tuser width
// - USER_BAD_FRAME_VALUE  1'b1            value ORed into tuser to mark a bad frame
// - LEN_WIDTH             16              width of length counters and limits
// PORTS
// - clk                   in   1           clock
// - rst                   in   1           synchronous, active-high reset
// - s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  per params  input stream
// - m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out          output stream
// - length_min            in   LEN_WIDTH   minimum legal frame bytes; 0 = no check
// - length_max            in   LEN_WIDTH   maximum legal frame bytes; 0 = no limit
// - status_frame_len      out  LEN_WIDTH   bytes accepted on input for the frame just ended (saturating)
// - status_frame_valid    out  1           1-cycle pulse: status_* outputs valid
// - status_oversize       out  1           1-cycle pulse with status_frame_valid: frame exceeded length_max
// - status_undersize      out  1           1-cycle pulse with status_frame_valid: frame below length_min
// BEHAVIOUR
// - Reset: m_axis_tvalid=0, all status outputs 0, state=PASS, byte count=0; reset mid-frame abandons the frame and the next accepted beat starts a new frame.
// - Datapath: single output register, latency 1 cycle; s_axis_tready = m_axis_tready | ~m_axis_tvalid in PASS, 1 in DROP; full throughput, no bubbles.
// - length_min/length_max are latched on the first beat of each frame; changes mid-frame have no effect.
// - Beat bytes = popcount(tkeep) (tkeep contiguous from LSB); cnt_next = cnt + beat bytes, saturating at 2^LEN_WIDTH-1.
// - State PASS: forward beats unchanged. On tlast: if length_min!=0 and cnt_next<length_min, tuser|=BAD on that beat; pulse status_undersize.
// - PASS -> DROP (truncate): non-last beat with length_max!=0 and cnt_next>=length_max: output beat with tkeep masked to the first (length_max-cnt) bytes, tlast=1, tuser|=BAD.
// - Exactly-at-limit: beat with cnt_next==length_max and tlast=1 is legal; no truncation, no flag.
// - Limit crossed on a tlast beat: beat tkeep masked to length_max bytes, tuser|=BAD, stay PASS, pulse status_oversize.
// - State DROP: accept and discard beats (m_axis_tvalid unaffected by them) until the tlast beat is accepted -> PASS; status pulse on that cycle with status_oversize=1.
// - Status pulse asserted the cycle after the input tlast beat is accepted; status_frame_len = full input byte count, including discarded bytes.
// - Undersize and oversize are mutually exclusive per frame; only one of the two flags can be set.
// - Byte count and latched limits clear on each accepted tlast.
// CONFIGURATION
// - Macro AXIS_FRAME_LEN_TRUNCATE_EN.
// - Defined: oversize frames are truncated as above (PASS/DROP state machine).
// - Not defined: no DROP state, and no tkeep masking or early tlast. An oversize frame passes whole, with tuser|=BAD on its original tlast beat. status_oversize still pulses.
// TESTING (DATA_WIDTH=32, KEEP_WIDTH=4, LEN_WIDTH=16)
// - 16-byte frame (4 full beats), min=0, max=0, m_axis_tready=1 -> identical beats out 1 cycle later; status_frame_len=16, no flags.
// - min=64, 10-byte frame (last tkeep=4'b0011) -> last output beat tuser=1; status_undersize=1, status_frame_len=10.
// - max=10, 20-byte frame, TRUNCATE_EN defined -> 3 beats out, third with tkeep=4'b0011, tlast=1, tuser=1; remaining 2 input beats dropped; status_oversize=1, len=20.
// - Same as above without TRUNCATE_EN -> all 5 beats out unmodified, last beat tuser=1; status_oversize=1.
// - max=12, 12-byte frame -> passes unmodified, no flags; random m_axis_tready backpressure -> no beat lost or duplicated, order preserved.
// - Assert rst mid-frame after 2 beats -> m_axis_tvalid=0 the next cycle, status outputs 0; the following 8-byte frame reports len=8.

Source files
------------

// File: rtl/axis_frame_len_limit.sv
// AXI4-Stream frame length checker/limiter: counts bytes per frame, flags runts and oversize frames.
// Define AXIS_FRAME_LEN_TRUNCATE_EN to truncate oversize frames (PASS/DROP); otherwise they pass whole, marked bad.
module axis_frame_len_limit #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_frame_valid,
  output logic                  status_oversize,
  output logic                  status_undersize
);

  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_min;
  logic [LEN_WIDTH-1:0]  r_max;
  logic                  r_in_frame;

  logic [KEEP_WIDTH-1:0] w_keep_in;
  logic [LEN_WIDTH-1:0]  w_beat_bytes;
  logic [LEN_WIDTH:0]    w_sum;
  logic [LEN_WIDTH-1:0]  w_cnt_next;
  logic [LEN_WIDTH-1:0]  w_min;
  logic [LEN_WIDTH-1:0]  w_max;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_over_last;
  logic                  w_under;
  logic                  w_bad;
  logic [KEEP_WIDTH-1:0] w_out_keep;
  logic                  w_out_last;

  // Without tkeep every beat counts as a full KEEP_WIDTH bytes.
  assign w_keep_in = s_axis_tkeep | {KEEP_WIDTH{KEEP_ENABLE == 0}};

  always_comb begin
    w_beat_bytes = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      w_beat_bytes = w_beat_bytes + LEN_WIDTH'(w_keep_in[i]);
    end
  end

  assign w_sum      = {1'b0, r_cnt} + {1'b0, w_beat_bytes};
  assign w_cnt_next = w_sum[LEN_WIDTH] ? '1 : w_sum[LEN_WIDTH-1:0];

  // Limits sampled live on a frame's first beat, held from the latch afterwards.
  assign w_min = r_in_frame ? r_min : length_min;
  assign w_max = r_in_frame ? r_max : length_max;

  assign s_axis_tready = w_drop | m_axis_tready | ~m_axis_tvalid;
  assign w_accept      = s_axis_tvalid & s_axis_tready;

  assign w_over_last = s_axis_tlast & ~w_drop & (w_max != '0) & (w_cnt_next > w_max);
  assign w_under     = s_axis_tlast & ~w_drop & ~w_over_last & (w_min != '0) & (w_cnt_next < w_min);

`ifdef AXIS_FRAME_LEN_TRUNCATE_EN
  typedef enum logic {ST_PASS = 1'b0, ST_DROP = 1'b1} state_t;
  state_t                r_state;
  logic                  w_trunc;
  logic [LEN_WIDTH-1:0]  w_avail;
  logic [KEEP_WIDTH-1:0] w_mask;

  assign w_drop  = (r_state == ST_DROP);
  assign w_trunc = ~s_axis_tlast & ~w_drop & (w_max != '0) & (w_cnt_next >= w_max);
  assign w_avail = w_max - r_cnt;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      w_mask[i] = (LEN_WIDTH'(i) < w_avail);
    end
  end

  assign w_out_keep = (w_trunc | w_over_last) ? (w_keep_in & w_mask) : w_keep_in;
  assign w_out_last = s_axis_tlast | w_trunc;
  assign w_bad      = w_under | w_over_last | w_trunc;
`else
  assign w_drop     = 1'b0;
  assign w_out_keep = w_keep_in;
  assign w_out_last = s_axis_tlast;
  assign w_bad      = w_under | w_over_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid      <= 1'b0;
      status_frame_len   <= '0;
      status_frame_valid <= 1'b0;
      status_oversize    <= 1'b0;
      status_undersize   <= 1'b0;
      r_cnt              <= '0;
      r_min              <= '0;
      r_max              <= '0;
      r_in_frame         <= 1'b0;
`ifdef AXIS_FRAME_LEN_TRUNCATE_EN
      r_state            <= ST_PASS;
`endif
    end else begin
      status_frame_valid <= 1'b0;
      status_oversize    <= 1'b0;
      status_undersize   <= 1'b0;

      if (w_accept && !w_drop) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= w_out_keep;
        m_axis_tlast  <= w_out_last;
        m_axis_tuser  <= s_axis_tuser | (w_bad ? USER_BAD_FRAME_VALUE : '0);
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (w_accept) begin
        if (s_axis_tlast) begin
          r_cnt              <= '0;
          r_in_frame         <= 1'b0;
          status_frame_valid <= 1'b1;
          status_frame_len   <= w_cnt_next;
          status_oversize    <= w_over_last | w_drop;
          status_undersize   <= w_under;
`ifdef AXIS_FRAME_LEN_TRUNCATE_EN
          r_state            <= ST_PASS;
`endif
        end else begin
          r_cnt      <= w_cnt_next;
          r_in_frame <= 1'b1;
          r_min      <= w_min;
          r_max      <= w_max;
`ifdef AXIS_FRAME_LEN_TRUNCATE_EN
          if (w_trunc) r_state <= ST_DROP;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_len_limit.sv
// Self-checking bench for axis_frame_len_limit: frame-level reference model, directed cases, random traffic.
// Honours AXIS_FRAME_LEN_TRUNCATE_EN the same way as the design.
module tb_axis_frame_len_limit;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [0:0]    s_user = '0;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic [0:0]    m_user;
  logic [LW-1:0] length_min = '0;
  logic [LW-1:0] length_max = '0;
  logic [LW-1:0] st_len;
  logic          st_valid;
  logic          st_over;
  logic          st_under;

  always #5 clk = ~clk;

  axis_frame_len_limit #(
    .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW), .USER_WIDTH(1),
    .USER_BAD_FRAME_VALUE(1'b1), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .length_min(length_min), .length_max(length_max),
    .status_frame_len(st_len), .status_frame_valid(st_valid),
    .status_oversize(st_over), .status_undersize(st_under)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l; logic u;} beat_t;
  typedef struct packed {logic [15:0] len; logic ov; logic un;} st_t;

  beat_t       exp_q[$];
  st_t         exp_st[$];
  logic [31:0] fd[$];
  int          fk[$];
  logic        fu[$];

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  bit   rand_rdy = 1'b0;
  int   out_beats = 0;
  logic [3:0] last_keep = '0;
  logic last_user = 1'b0;
  st_t  last_st = '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Frame-level model: running byte total decides truncation point and flags.
  task automatic build_expect(input int mn, input int mx);
    int  cnt = 0;
    int  nxt;
    bit  cut = 1'b0;
    bit  ov = 1'b0;
    bit  un = 1'b0;
    int  n = fk.size();
    st_t s;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      bit lst;
      lst = (i == n - 1);
      nxt = cnt + fk[i];
      if (nxt > 65535) nxt = 65535;
      b.d = fd[i];
      b.k = 4'((1 << fk[i]) - 1);
      b.l = lst;
      b.u = fu[i];
      if (!cut) begin
`ifdef AXIS_FRAME_LEN_TRUNCATE_EN
        if (!lst && mx != 0 && nxt >= mx) begin
          b.k = 4'((1 << (mx - cnt)) - 1); b.l = 1'b1; b.u = 1'b1; cut = 1'b1; ov = 1'b1;
        end else if (lst && mx != 0 && nxt > mx) begin
          b.k = 4'((1 << (mx - cnt)) - 1); b.u = 1'b1; ov = 1'b1;
        end
`else
        if (lst && mx != 0 && nxt > mx) begin
          b.u = 1'b1; ov = 1'b1;
        end
`endif
        else if (lst && mn != 0 && nxt < mn) begin
          b.u = 1'b1; un = 1'b1;
        end
        exp_q.push_back(b);
      end
      cnt = nxt;
    end
    s.len = 16'(cnt);
    s.ov  = ov;
    s.un  = un;
    exp_st.push_back(s);
  endtask

  task automatic make_frame(input int nbeats, input int lastbytes, input bit rnd);
    fd.delete(); fk.delete(); fu.delete();
    for (int i = 0; i < nbeats; i++) begin
      fd.push_back($urandom);
      if (i == nbeats - 1) fk.push_back(lastbytes);
      else if (rnd && $urandom_range(0, 3) == 0) fk.push_back(int'($urandom_range(1, 4)));
      else fk.push_back(4);
      fu.push_back(rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
    end
  endtask

  // Entered and left at posedge+#1; returns once the beat has been accepted.
  task automatic drive_beat(input logic [31:0] d, input int nb, input logic l, input logic u, input bit idle);
    int w = 0;
    if (idle) begin
      while ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_data = d; s_keep = 4'((1 << nb) - 1); s_last = l; s_user = u; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      w++;
      if (w > 1000) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat not accepted after %0d cycles, required <= 1000", w);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int mn, input int mx, input bit idle, input bit chg);
    int n = fd.size();
    build_expect(mn, mx);
    length_min = 16'(mn);
    length_max = 16'(mx);
    for (int i = 0; i < n; i++) begin
      drive_beat(fd[i], fk[i], (i == n - 1), fu[i], idle);
      if (i == 0 && chg) begin
        length_min = 16'($urandom_range(0, 60));
        length_max = 16'($urandom_range(0, 60));
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || exp_st.size() != 0); i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0 || exp_st.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending beats %0d status %0d, required 0 0", exp_q.size(), exp_st.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Compare process: every output handshake and every status pulse against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        if (m_valid && m_ready) begin
          beat_t a;
          a.d = m_data; a.k = m_keep; a.l = m_last; a.u = m_user[0];
          out_beats++;
          last_keep = m_keep;
          last_user = m_user[0];
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_beat: unexpected beat d=%h k=%b l=%b u=%b, required none", m_data, m_keep, m_last, m_user);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (a !== e) begin
              errors++;
              $display("FAIL out_beat: got d=%h k=%b l=%b u=%b expected d=%h k=%b l=%b u=%b",
                       a.d, a.k, a.l, a.u, e.d, e.k, e.l, e.u);
            end
          end
        end
        checks++;
        if (st_valid) begin
          st_t a2;
          a2.len = st_len; a2.ov = st_over; a2.un = st_under;
          last_st = a2;
          if (exp_st.size() == 0) begin
            errors++;
            $display("FAIL status: unexpected pulse len=%0d ov=%b un=%b, required none", st_len, st_over, st_under);
          end else begin
            st_t e2;
            e2 = exp_st.pop_front();
            if (a2 !== e2) begin
              errors++;
              $display("FAIL status: got len=%0d ov=%b un=%b expected len=%0d ov=%b un=%b",
                       a2.len, a2.ov, a2.un, e2.len, e2.ov, e2.un);
            end
          end
        end else if (st_over || st_under) begin
          errors++;
          $display("FAIL status_flags: got ov=%b un=%b without valid, required 0 0", st_over, st_under);
        end
      end
    end
  end

  initial begin
    int ob;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", m_valid, 0);
    chk("reset_status_valid", st_valid, 0);
    chk("reset_status_flags", {st_over, st_under}, 0);
    chk("reset_status_len", st_len, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // 16-byte frame, no limits
    ob = out_beats;
    make_frame(4, 4, 1'b0);
    send_frame(0, 0, 1'b0, 1'b0);
    drain();
    chk("plain_beats", out_beats - ob, 4);
    chk("plain_len", last_st.len, 16);
    chk("plain_flags", {last_st.ov, last_st.un}, 0);

    // runt: min=64, 10 bytes
    make_frame(3, 2, 1'b0);
    send_frame(64, 0, 1'b0, 1'b0);
    drain();
    chk("runt_len", last_st.len, 10);
    chk("runt_under", last_st.un, 1);
    chk("runt_user", last_user, 1);

    // oversize: max=10, 20 bytes
    ob = out_beats;
    make_frame(5, 4, 1'b0);
    send_frame(0, 10, 1'b0, 1'b0);
    drain();
    chk("over_len", last_st.len, 20);
    chk("over_flags", {last_st.ov, last_st.un}, 2);
    chk("over_user", last_user, 1);
`ifdef AXIS_FRAME_LEN_TRUNCATE_EN
    chk("over_beats", out_beats - ob, 3);
    chk("over_keep", last_keep, 4'b0011);
`else
    chk("over_beats", out_beats - ob, 5);
    chk("over_keep", last_keep, 4'b1111);
`endif

    // exactly at limit, with backpressure
    rand_rdy = 1'b1;
    ob = out_beats;
    make_frame(3, 4, 1'b0);
    send_frame(0, 12, 1'b1, 1'b0);
    drain();
    chk("exact_beats", out_beats - ob, 3);
    chk("exact_len", last_st.len, 12);
    chk("exact_flags", {last_st.ov, last_st.un, last_user}, 0);

    // reset mid-frame after 2 beats
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    length_min = '0; length_max = '0;
    drive_beat(32'h1111_1111, 4, 1'b0, 1'b0, 1'b0);
    drive_beat(32'h2222_2222, 4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tvalid", m_valid, 0);
    chk("midrst_status", {st_valid, st_over, st_under}, 0);
    chk("midrst_len", st_len, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    make_frame(2, 4, 1'b0);
    send_frame(0, 0, 1'b0, 1'b0);
    drain();
    chk("postrst_len", last_st.len, 8);

    // saturating byte count
    make_frame(16400, 4, 1'b0);
    send_frame(0, 0, 1'b0, 1'b0);
    drain();
    chk("sat_len", last_st.len, 65535);

    // random traffic with backpressure and mid-frame limit changes
    rand_rdy = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int mn;
      int mx;
      mn = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      mx = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      make_frame(int'($urandom_range(1, 10)), int'($urandom_range(1, 4)), 1'b1);
      send_frame(mn, mx, 1'b1, 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
